// File: rtl/lightboard_eth_pkg.sv
// lightboard_eth_pkg: shared Ethernet TX framing constants, state encoding and CRC-32 dibit step.
package lightboard_eth_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_SFD, S_HEADER, S_PAYLOAD, S_PAD, S_FCS, S_IFG} state_t;
  localparam int PREAMBLE_DIBITS = 28;
  localparam int SFD_DIBITS = 4;
  localparam int HEADER_DIBITS = 56;
  localparam int MIN_PAYLOAD_DIBITS = 184;
  localparam int FCS_DIBITS = 16;
  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT = 2'b01;
  localparam logic [1:0] SFD_LAST_DIBIT = 2'b11;
  // Bit-reversed form of 0x04C11DB7, shifted right for LSb-first data
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] n;
    n = c;
    for (int i = 0; i < 2; i++) n = (n[0] ^ d[i]) ? (n >> 1) ^ CRC_POLY : n >> 1;
    return n;
  endfunction
endpackage

// File: rtl/crc32_dibit.sv
// crc32_dibit: IEEE 802.3 CRC-32 absorbing one dibit (bit 0 first) per enabled cycle; output is complemented.
module crc32_dibit
  import lightboard_eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [1:0]  d,
  output logic [31:0] crc
);
  logic [31:0] r;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r <= CRC_INIT;
    else if (clear) r <= CRC_INIT;
    else if (en) r <= crc_step(r, d);
  end
  assign crc = ~r;
endmodule

// File: rtl/eth_frame_tx.sv
// eth_frame_tx: RMII dibit frame transmitter: preamble, SFD, header, payload, pad, FCS, inter-frame gap.
// Define ETH_FCS_EN to compile in the CRC-32 unit and FCS state; otherwise frames end after pad.
module eth_frame_tx
  import lightboard_eth_pkg::*;
#(
  parameter logic [47:0] DEST_MAC = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC = 48'h00_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int PAYLOAD_MAX_DIBITS = 1292,
  parameter int IFG_DIBITS = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       stall,
  output logic       axiov,
  output logic [1:0] axiod
);
  localparam logic [111:0] HDR = {DEST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [15:0] PMAX = 16'(PAYLOAD_MAX_DIBITS);
  localparam logic [15:0] PMIN = 16'(MIN_PAYLOAD_DIBITS);
`ifdef ETH_FCS_EN
  localparam state_t POST = S_FCS;
`else
  localparam state_t POST = S_IFG;
`endif
  state_t state, cur, nxt;
  logic [15:0] cnt, len;
  logic rdy, ov;
  logic [1:0] dout;
  logic [6:0] hidx;
`ifdef ETH_FCS_EN
  logic [31:0] crc;
  crc32_dibit u_crc (
    .clk(clk), .rst(rst), .clear(cur == S_IDLE),
    .en(cur inside {S_HEADER, S_PAYLOAD, S_PAD}), .d(dout), .crc(crc)
  );
`endif
  // A payload slot without valid data is already the first slot of whatever follows, so the wire never idles
  always_comb begin
    cur = (state == S_PAYLOAD && !axiiv) ? (len >= PMIN ? POST : S_PAD) : state;
    hidx = 7'd104 - {cnt[5:2], 3'b000} + {4'b0000, cnt[1:0], 1'b0};
    nxt = cur;
    ov = 1'b1;
    dout = 2'b00;
    case (cur)
      S_IDLE: begin
        ov = 1'b0;
        if (enable) nxt = rdy ? S_PREAMBLE : S_IFG;
      end
      S_PREAMBLE: begin
        dout = PREAMBLE_DIBIT;
        if (cnt == 16'(PREAMBLE_DIBITS - 1)) nxt = S_SFD;
      end
      S_SFD: begin
        dout = (cnt == 16'(SFD_DIBITS - 1)) ? SFD_LAST_DIBIT : SFD_DIBIT;
        if (cnt == 16'(SFD_DIBITS - 1)) nxt = S_HEADER;
      end
      S_HEADER: begin
        dout = HDR[hidx +: 2];
        if (cnt == 16'(HEADER_DIBITS - 1)) nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        dout = axiid;
        if (len == PMAX - 16'd1) nxt = (len + 16'd1 >= PMIN) ? POST : S_PAD;
      end
      S_PAD: if (len >= PMIN - 16'd1) nxt = POST;
`ifdef ETH_FCS_EN
      S_FCS: begin
        dout = crc[{cnt[3:0], 1'b0} +: 2];
        if (cnt == 16'(FCS_DIBITS - 1)) nxt = S_IFG;
      end
`endif
      S_IFG: begin
        ov = 1'b0;
        if (cnt == 16'(IFG_DIBITS - 1)) nxt = S_IDLE;
      end
      default: ;
    endcase
  end
  // rdy stays low after reset so the first frame is always preceded by a full gap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      len <= '0;
      rdy <= 1'b0;
      stall <= 1'b1;
      axiov <= 1'b0;
      axiod <= 2'b00;
    end else begin
      state <= nxt;
      cnt <= (nxt != cur || cur inside {S_IDLE, S_PAYLOAD, S_PAD}) ? '0 : cnt + 16'd1;
      len <= (cur inside {S_PAYLOAD, S_PAD}) ? len + 16'd1 : '0;
      rdy <= rdy | (cur == S_IFG && nxt == S_IDLE);
      stall <= !((cur == S_HEADER && cnt >= 16'(HEADER_DIBITS - 2)) || (cur == S_PAYLOAD && len != PMAX - 16'd1));
      axiov <= ov;
      axiod <= dout;
    end
  end
endmodule

// File: tb/tb_eth_frame_tx.sv
// tb_eth_frame_tx: table-driven frame checks plus reset, idle and CRC-unit sequences for eth_frame_tx.
module tb_eth_frame_tx;
  typedef struct {int feed; bit inc; logic [1:0] pat; bit junk; int pay; int len;} vec_t;
`ifdef ETH_FCS_EN
  localparam int FCSL = 16;
`else
  localparam int FCSL = 0;
`endif
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, axiiv = 1'b0;
  logic [1:0] axiid = 2'b00;
  logic stall, axiov;
  logic [1:0] axiod;
  logic c_clear = 1'b0, c_en = 1'b0;
  logic [1:0] c_d = 2'b00;
  logic [31:0] c_crc;
  int tests = 0, fails = 0;
  int feed_n = 0, sent = 0;
  bit inc = 1'b0, junk = 1'b0;
  logic [1:0] pat = 2'b00;
  logic prev_stall = 1'b1, s_ov = 1'b0, s_st = 1'b1;
  logic [1:0] s_od = 2'b00;
  logic [1:0] got[$], exp[$];
  logic gst[$];
  logic [1:0] hdr_exp[56];

  always #5 clk = ~clk;

  eth_frame_tx dut (.clk(clk), .rst(rst), .enable(enable), .axiiv(axiiv), .axiid(axiid),
                    .stall(stall), .axiov(axiov), .axiod(axiod));
  crc32_dibit u_crc (.clk(clk), .rst(rst), .clear(c_clear), .en(c_en), .d(c_d), .crc(c_crc));

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic seg(string name, int lo, int hi);
    int bad;
    bad = -1;
    if (lo >= hi) return;
    tests++;
    for (int k = lo; k < hi; k++) if (bad < 0 && (k >= got.size() || got[k] !== exp[k])) bad = k;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s: dibit %0d got %b expected %b", name, bad, bad < got.size() ? got[bad] : 2'bxx, exp[bad]);
    end
  endtask

  // Sample outputs mid-cycle, then drive the upstream as a registered source reacting to last cycle's stall
  task automatic cyc();
    @(negedge clk);
    s_ov = axiov;
    s_od = axiod;
    s_st = stall;
    if (!prev_stall && sent < feed_n) begin
      axiiv = 1'b1;
      axiid = inc ? 2'(sent) : pat;
      sent++;
    end else begin
      axiiv = prev_stall & junk;
      axiid = axiiv ? 2'b11 : 2'b00;
    end
    prev_stall = stall;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin cyc(); n++; end while (!s_ov && n < 400);
    if (!s_ov) begin
      tests++;
      fails++;
      $display("FAIL start: axiov stayed 0 for %0d cycles, expected a frame", n);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "frame start timeout");
    end
  endtask

  task automatic collect();
    got.delete();
    gst.delete();
    while (s_ov && got.size() < 3000) begin
      got.push_back(s_od);
      gst.push_back(s_st);
      cyc();
    end
  endtask

  function automatic logic st_at(int k);
    return k < gst.size() ? gst[k] : 1'bx;
  endfunction

  task automatic build_exp(vec_t v);
    exp.delete();
    for (int k = 0; k < 31; k++) exp.push_back(2'b01);
    exp.push_back(2'b11);
    for (int k = 0; k < 56; k++) exp.push_back(hdr_exp[k]);
    for (int k = 0; k < v.pay; k++) exp.push_back(v.inc ? 2'(k) : v.pat);
    for (int k = v.pay; k < 184; k++) exp.push_back(2'b00);
`ifdef ETH_FCS_EN
    begin
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int k = 32; k < exp.size(); k++)
        for (int b = 0; b < 2; b++) c = (c[0] ^ exp[k][b]) ? (c >> 1) ^ 32'hEDB8_8320 : c >> 1;
      c = ~c;
      for (int k = 0; k < 16; k++) exp.push_back(c[2*k +: 2]);
    end
`endif
  endtask

  initial begin
    vec_t v[6];
    int n, hi;
    bit any;
    byte ch;
    string s;
    v[0] = '{feed: 8,    inc: 1'b0, pat: 2'b10, junk: 1'b1, pay: 8,    len: 272 + FCSL};
    v[1] = '{feed: 0,    inc: 1'b0, pat: 2'b00, junk: 1'b0, pay: 0,    len: 272 + FCSL};
    v[2] = '{feed: 200,  inc: 1'b1, pat: 2'b00, junk: 1'b1, pay: 200,  len: 288 + FCSL};
    v[3] = '{feed: 5000, inc: 1'b1, pat: 2'b00, junk: 1'b0, pay: 1292, len: 1380 + FCSL};
    v[4] = '{feed: 183,  inc: 1'b0, pat: 2'b01, junk: 1'b0, pay: 183,  len: 272 + FCSL};
    v[5] = '{feed: 184,  inc: 1'b0, pat: 2'b11, junk: 1'b1, pay: 184,  len: 272 + FCSL};
    for (int k = 0; k < 24; k++) hdr_exp[k] = 2'b11;
    for (int k = 24; k < 56; k++) hdr_exp[k] = 2'b00;
    hdr_exp[44] = 2'b01;
    hdr_exp[49] = 2'b10; hdr_exp[51] = 2'b10;
    hdr_exp[52] = 2'b01; hdr_exp[53] = 2'b01; hdr_exp[54] = 2'b11; hdr_exp[55] = 2'b10;
    #12;
    check("reset_stall", stall, 1);
    check("reset_axiov", axiov, 0);
    check("reset_axiod", axiod, 0);
    @(negedge clk);
    rst = 1'b1;
    c_clear = 1'b1;
    @(negedge clk);
    c_clear = 1'b0;
    check("crc_clear", c_crc, 32'h0);
    s = "123456789";
    for (int i = 0; i < 9; i++)
      for (int k = 0; k < 4; k++) begin
        ch = s[i];
        c_en = 1'b1;
        c_d = ch[2*k +: 2];
        @(negedge clk);
      end
    c_en = 1'b0;
    check("crc_check", c_crc, 32'hCBF4_3926);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      feed_n = v[i].feed; sent = 0; inc = v[i].inc; pat = v[i].pat; junk = v[i].junk;
      wait_start(n);
      if (i > 0) check($sformatf("c%0d_ifg_ge48", i), n >= 48, 1);
      enable = 1'b0;
      collect();
      enable = 1'b1;
      build_exp(v[i]);
      check($sformatf("c%0d_len", i), got.size(), v[i].len);
      seg($sformatf("c%0d_preamble_sfd", i), 0, 32);
      seg($sformatf("c%0d_header", i), 32, 88);
      seg($sformatf("c%0d_payload", i), 88, 88 + v[i].pay);
      seg($sformatf("c%0d_pad", i), 88 + v[i].pay, 272);
`ifdef ETH_FCS_EN
      seg($sformatf("c%0d_fcs", i), v[i].len - 16, v[i].len);
`endif
      check($sformatf("c%0d_stall_hdr53", i), st_at(85), 1);
      check($sformatf("c%0d_stall_hdr55", i), st_at(87), 0);
      hi = (v[i].pay == 1292) ? 87 + 1292 : 88 + v[i].pay;
      if (hi < v[i].len) check($sformatf("c%0d_stall_end", i), st_at(hi), 1);
    end
    feed_n = 5000; sent = 0; inc = 1'b1; junk = 1'b0;
    wait_start(n);
    check("rst_pre_ifg_ge48", n >= 48, 1);
    for (int k = 0; k < 150; k++) cyc();
    rst = 1'b0;
    #1;
    check("midframe_rst_axiov", axiov, 0);
    check("midframe_rst_stall", stall, 1);
    check("midframe_rst_axiod", axiod, 0);
    for (int k = 0; k < 5; k++) cyc();
    rst = 1'b1;
    enable = 1'b0;
    any = 1'b0;
    for (int k = 0; k < 60; k++) begin cyc(); any |= s_ov; end
    check("idle_without_enable", any, 0);
    enable = 1'b1;
    wait_start(n);
    check("post_reset_gap_ge48", n >= 48, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/eth_frame_tx.md
ETH_FRAME_TX -- requirements
Module: eth_frame_tx

Interface
REQ-001 SHALL have parameter DEST_MAC, default 48'hFF_FF_FF_FF_FF_FF, destination MAC inserted in the header.
REQ-002 SHALL have parameter SRC_MAC, default 48'h00_00_00_00_00_01, source MAC inserted in the header.
REQ-003 SHALL have parameter ETHERTYPE, default 16'h88B5, EtherType inserted in the header.
REQ-004 SHALL have parameter PAYLOAD_MAX_DIBITS, default 1292, maximum payload length in dibits.
REQ-005 SHALL have parameter IFG_DIBITS, default 48, inter-frame gap length in cycles.
REQ-006 SHALL have port clk, input, 1, the only clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port enable, input, 1, which permits a new frame to start from IDLE.
REQ-009 SHALL have port axiiv, input, 1, upstream payload dibit valid.
REQ-010 SHALL have port axiid, input, 2, upstream payload dibit.
REQ-011 SHALL have port stall, output, 1, registered; high holds the upstream serializer in its address-restart state.
REQ-012 SHALL have port axiov, output, 2-wire RMII-style transmit enable (width 1), registered.
REQ-013 SHALL have port axiod, output, 2, transmit dibit, registered.

Function
REQ-014 SHALL step through states IDLE -> PREAMBLE -> SFD -> HEADER -> PAYLOAD -> PAD -> FCS -> IFG -> IDLE, advancing one dibit per cycle.
REQ-015 SHALL leave IDLE only when enable=1; PREAMBLE SHALL drive 28 dibits of 2'b01 with axiov=1.
REQ-016 SHALL drive SFD as dibits 01, 01, 01, 11, in that order.
REQ-017 SHALL send the 14-byte header DEST_MAC, SRC_MAC, ETHERTYPE as 56 dibits, most-significant byte first and least-significant dibit first within each byte.
REQ-018 SHALL register stall low two cycles before the first PAYLOAD slot, covering the one-cycle registered latency in each direction.
REQ-019 SHALL forward axiid to axiod unchanged in PAYLOAD, one cycle later.
REQ-020 SHALL end PAYLOAD on the first payload-slot cycle with axiiv=0, or after PAYLOAD_MAX_DIBITS dibits, whichever comes first.
REQ-021 SHALL register stall high on the cycle the payload counter reaches PAYLOAD_MAX_DIBITS-1 or axiiv is seen low.
REQ-022 SHALL ignore axiiv=1 outside PAYLOAD slots; such dibits are dropped and never transmitted.
REQ-023 SHALL in PAD append 2'b00 dibits until payload plus pad equals 184 dibits (46 bytes); PAD SHALL be skipped when payload is at least 184 dibits.
REQ-024 SHALL compute the IEEE 802.3 CRC-32 over header, payload and pad: reflected polynomial 0x04C11DB7, init 32'hFFFFFFFF, complemented result.
REQ-025 SHALL send the CRC-32 in FCS as 16 dibits, least-significant bit first.
REQ-026 SHALL hold axiov=0 and axiod=0 for IFG_DIBITS cycles in IFG.
REQ-027 SHALL keep stall=1 in every state except the payload window defined in REQ-018 and REQ-021.
REQ-028 SHALL ignore a change of enable during a frame; the change takes effect only in IDLE.
REQ-029 SHALL, for a zero-length payload (axiiv=0 at the first slot), send 184 pad dibits.

Reset
REQ-030 SHALL, while rst=0, asynchronously force state=IDLE, stall=1, axiov=0, axiod=0, all counters to 0 and the CRC register to 32'hFFFFFFFF.
REQ-031 SHALL on reset mid-frame truncate the frame at once, with no FCS, and start the next frame only after rst=1, enable=1 and a full IFG_DIBITS gap.

Configuration
REQ-032 SHALL, with ETH_FCS_EN defined, compile in the CRC logic and the FCS state.
REQ-033 SHALL, with ETH_FCS_EN undefined, omit the CRC logic and go straight from PAD/PAYLOAD to IFG; all other timing is unchanged.

Structure
REQ-034 SHALL take from shared package lightboard_eth_pkg: the state enum, PREAMBLE_DIBITS=28, SFD dibit constants, MIN_PAYLOAD_DIBITS=184, FCS_DIBITS=16, and the CRC polynomial and initial value.
REQ-035 SHALL put the CRC in sub-module crc32_dibit (clear, enable, 2-bit data in, 32-bit CRC out), updated one dibit per cycle.

Verification
REQ-036 Reset: rst=0 mid-PAYLOAD -> same-cycle axiov=0 and stall=1; after release, the first preamble starts no earlier than 48 cycles after enable.
REQ-037 Framing: enable=1, upstream idle -> 28x 01, then 01 01 01 11, then header dibits for DEST_MAC FF..FF starting 11 11 11 11.
REQ-038 Short payload: upstream supplies 8 dibits of 2'b10 -> 8 forwarded dibits, 176 pad dibits of 00, then FCS, then 48 idle cycles.
REQ-039 Max payload: upstream always valid -> exactly 1292 payload dibits, stall high by payload dibit 1291, no pad.
REQ-040 CRC unit: crc32_dibit fed ASCII "123456789" LSb-first -> final complemented value 32'hCBF43926.
REQ-041 Macro off: build without ETH_FCS_EN -> IFG starts the cycle after the last pad dibit.
